// File: rtl/k2mul_iter_pkg.sv
// Shared widths and FSM encoding for the digit-serial multiplier feeding k2red_s.
package k2mul_iter_pkg;

    localparam int W     = 64;
    localparam int DIGIT = 16;
    localparam int TAGW  = 4;
    localparam int NDIG  = W / DIGIT;
    localparam int CNTW  = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/k2mul_iter_if.sv
// Operand/result handshake bundle between a producer/consumer (master) and k2mul_iter (slave).
interface k2mul_iter_if;
    import k2mul_iter_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    X;
    logic [W-1:0]    Y;
    logic [TAGW-1:0] in_tag;
    logic            out_valid;
    logic            out_ready;
    logic [2*W-1:0]  P;
    logic [TAGW-1:0] out_tag;

    modport master (
        output in_valid, X, Y, in_tag, out_ready,
        input  in_ready, out_valid, P, out_tag
    );

    modport slave (
        input  in_valid, X, Y, in_tag, out_ready,
        output in_ready, out_valid, P, out_tag
    );

endinterface

// File: rtl/k2mul_row.sv
// Combinational W x DIGIT unsigned row product; isolated so it can be retimed or mapped to a DSP.
module k2mul_row #(
    parameter int W     = 64,
    parameter int DIGIT = 16
) (
    input  logic [W-1:0]       x,
    input  logic [DIGIT-1:0]   d,
    output logic [W+DIGIT-1:0] prod
);

    assign prod = {{DIGIT{1'b0}}, x} * {{W{1'b0}}, d};

endmodule

// File: rtl/k2mul_iter.sv
// Iterative unsigned multiplier: one DIGIT slice of Y per cycle, exact 2W-bit product held until taken.
module k2mul_iter
    import k2mul_iter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    k2mul_iter_if.slave bus
);

    state_t            state_reg, state_next;
    logic [W-1:0]      x_reg, y_reg;
    logic [TAGW-1:0]   tag_reg, out_tag_reg;
    logic [CNTW-1:0]   cnt_reg;
    logic [2*W-1:0]    acc_reg, acc_next, p_reg;
    logic [2*W-1:0]    row_ext;
    logic [W+DIGIT-1:0] row;
    logic [DIGIT-1:0]  y_digit [NDIG];
    logic [DIGIT-1:0]  digit;
    logic              accept;
    logic              last;

    generate
        for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
            assign y_digit[gi] = y_reg[gi*DIGIT +: DIGIT];
        end
    endgenerate

    assign digit = y_digit[cnt_reg];

    k2mul_row #(.W(W), .DIGIT(DIGIT)) u_row (
        .x    (x_reg),
        .d    (digit),
        .prod (row)
    );

    assign row_ext  = {{(W-DIGIT){1'b0}}, row};
    assign acc_next = acc_reg + (row_ext << (int'(cnt_reg) * DIGIT));
    assign last     = (cnt_reg == CNTW'(NDIG-1));

    // out_ready reaches in_ready combinationally so a result can retire and a new op latch together.
    assign bus.in_ready  = (state_reg == S_IDLE) || ((state_reg == S_DONE) && bus.out_ready);
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = (state_reg == S_DONE);
    assign bus.P         = p_reg;
    assign bus.out_tag   = out_tag_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (accept) state_next = S_MUL;
            S_MUL:  if (last)   state_next = S_DONE;
            S_DONE: begin
                if (accept)             state_next = S_MUL;
                else if (bus.out_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= S_IDLE;
            x_reg       <= '0;
            y_reg       <= '0;
            tag_reg     <= '0;
            cnt_reg     <= '0;
            acc_reg     <= '0;
            p_reg       <= '0;
            out_tag_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                x_reg   <= bus.X;
                y_reg   <= bus.Y;
                tag_reg <= bus.in_tag;
                acc_reg <= '0;
                cnt_reg <= '0;
            end else if (state_reg == S_MUL) begin
                acc_reg <= acc_next;
                cnt_reg <= cnt_reg + CNTW'(1);
                // P only moves on the edge into DONE, so it is stable for the whole DONE stay.
                if (last) begin
                    p_reg       <= acc_next;
                    out_tag_reg <= tag_reg;
                end
            end
        end
    end

endmodule

// File: tb/tb_k2mul_iter.sv
// Directed and random checks of k2mul_iter against an in-order product scoreboard.
module tb_k2mul_iter;
    import k2mul_iter_pkg::*;

    typedef struct {
        logic [2*W-1:0]  p;
        logic [TAGW-1:0] tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   compared   = 0;
    int   mismatched = 0;
    exp_t sb[$];

    k2mul_iter_if bus();

    k2mul_iter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One clock: drive at negedge, sample handshakes, then advance to the next negedge.
    task automatic step(input logic iv, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [TAGW-1:0] tg, input logic ordy,
                        output logic acc, output logic rt);
        bus.in_valid  = iv;
        bus.X         = x;
        bus.Y         = y;
        bus.in_tag    = tg;
        bus.out_ready = ordy;
        #1;
        rt  = bus.out_valid && ordy;
        acc = iv && bus.in_ready;
        if (rt) begin
            check("sb_nonempty", (2*W)'(sb.size() != 0), (2*W)'(1));
            if (sb.size() != 0) begin
                exp_t e = sb.pop_front();
                $display("retire tag=%h P=%h", bus.out_tag, bus.P);
                check("P", bus.P, e.p);
                check("out_tag", (2*W)'(bus.out_tag), (2*W)'(e.tag));
            end
        end
        if (acc) sb.push_back('{p: {{W{1'b0}}, x} * {{W{1'b0}}, y}, tag: tg});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_valid(input string tag);
        logic a, r;
        int   n = 0;
        while (!bus.out_valid && n < 2*NDIG + 4) begin
            step(1'b0, '0, '0, '0, 1'b0, a, r);
            n++;
        end
        check(tag, (2*W)'(bus.out_valid), (2*W)'(1));
    endtask

    initial begin
        logic            a, r;
        logic [2*W-1:0]  ep;
        logic [W-1:0]    xs [2];
        logic [W-1:0]    ys [2];
        logic [W-1:0]    rx, ry;
        logic [TAGW-1:0] rtag;
        int              first_rt, second_rt, second_acc, op, done_ops, n;
        logic            pending, iv, ordy;

        bus.in_valid  = 1'b0;
        bus.X         = '0;
        bus.Y         = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_out_valid", (2*W)'(bus.out_valid), '0);
        check("rst_P", bus.P, '0);
        check("rst_out_tag", (2*W)'(bus.out_tag), '0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_in_ready", (2*W)'(bus.in_ready), (2*W)'(1));

        // 3*5, latency and in_ready low while busy
        step(1'b1, 64'd3, 64'd5, 4'hA, 1'b0, a, r);
        check("t1_accept", (2*W)'(a), (2*W)'(1));
        for (int k = 1; k < NDIG; k++) begin
            step(1'b1, 64'hDEAD, 64'hBEEF, 4'h5, 1'b0, a, r);
            check("t1_busy_accept", (2*W)'(a), '0);
            check("t1_early_valid", (2*W)'(bus.out_valid), '0);
        end
        step(1'b0, '0, '0, '0, 1'b0, a, r);
        check("t1_valid", (2*W)'(bus.out_valid), (2*W)'(1));
        check("t1_P", bus.P, (2*W)'(15));
        check("t1_tag", (2*W)'(bus.out_tag), (2*W)'(4'hA));
        step(1'b0, '0, '0, '0, 1'b1, a, r);
        check("t1_retire", (2*W)'(r), (2*W)'(1));
        check("t1_valid_after", (2*W)'(bus.out_valid), '0);

        // Full-scale operands
        step(1'b1, '1, '1, 4'h3, 1'b0, a, r);
        wait_valid("t2_valid");
        check("t2_P", bus.P, 128'hFFFFFFFFFFFFFFFE_0000000000000001);
        step(1'b0, '0, '0, '0, 1'b1, a, r);

        // Backpressure for 10 cycles with a new op waiting
        step(1'b1, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 4'h6, 1'b0, a, r);
        ep = {{W{1'b0}}, 64'h1234_5678_9ABC_DEF0} * {{W{1'b0}}, 64'h0FED_CBA9_8765_4321};
        wait_valid("t3_valid");
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 64'd11, 64'd13, 4'h7, 1'b0, a, r);
            check("t3_hold_P", bus.P, ep);
            check("t3_hold_tag", (2*W)'(bus.out_tag), (2*W)'(4'h6));
            check("t3_no_accept", (2*W)'(a), '0);
            check("t3_hold_valid", (2*W)'(bus.out_valid), (2*W)'(1));
        end
        step(1'b0, '0, '0, '0, 1'b1, a, r);
        check("t3_retire", (2*W)'(r), (2*W)'(1));
        check("t3_valid_after", (2*W)'(bus.out_valid), '0);

        // Back-to-back with chained accept in DONE
        xs[0] = 64'd1;          ys[0] = 64'h8000_0000_0000_0000;
        xs[1] = 64'h1_0000_0000; ys[1] = 64'h1_0000_0000;
        first_rt = -1; second_rt = -1; second_acc = -1; op = 0;
        for (int k = 0; k < 15; k++) begin
            if (op < 2) step(1'b1, xs[op], ys[op], 4'(op + 1), 1'b1, a, r);
            else        step(1'b0, '0, '0, '0, 1'b1, a, r);
            if (r) begin
                if (first_rt < 0) first_rt = k;
                else              second_rt = k;
            end
            if (a) begin
                if (op == 1) second_acc = k;
                op++;
            end
        end
        check("t4_first_rt", (2*W)'(first_rt), (2*W)'(NDIG + 1));
        check("t4_second_acc", (2*W)'(second_acc), (2*W)'(NDIG + 1));
        check("t4_second_rt", (2*W)'(second_rt), (2*W)'(2*NDIG + 2));

        // Asynchronous reset mid-multiply discards the op
        step(1'b1, 64'd123, 64'd456, 4'h9, 1'b0, a, r);
        step(1'b0, '0, '0, '0, 1'b0, a, r);
        step(1'b0, '0, '0, '0, 1'b0, a, r);
        #2 rst = 1'b0;
        #1;
        check("t5_rst_valid", (2*W)'(bus.out_valid), '0);
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 2*NDIG; k++) begin
            step(1'b0, '0, '0, '0, 1'b1, a, r);
            check("t5_no_output", (2*W)'(bus.out_valid), '0);
        end
        check("t5_in_ready", (2*W)'(bus.in_ready), (2*W)'(1));
        step(1'b1, 64'd7, 64'd9, 4'h5, 1'b0, a, r);
        wait_valid("t5_valid");
        check("t5_P", bus.P, (2*W)'(63));
        step(1'b0, '0, '0, '0, 1'b1, a, r);

        // Random operands and handshakes, source holds data until accepted
        done_ops = 0; pending = 1'b0; n = 0;
        rx = '0; ry = '0; rtag = '0;
        while (done_ops < 1000 && n < 40000) begin
            if (!pending) begin
                rx = {$urandom, $urandom};
                ry = {$urandom, $urandom};
                if ($urandom_range(0, 15) == 0) rx = '0;
                if ($urandom_range(0, 15) == 0) ry = '0;
                if ($urandom_range(0, 15) == 0) ry = '1;
                rtag = 4'($urandom_range(0, 15));
                pending = 1'b1;
            end
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            step(iv, rx, ry, rtag, ordy, a, r);
            if (a) begin
                pending = 1'b0;
                done_ops++;
            end
            n++;
        end
        check("t6_ops", (2*W)'(done_ops), (2*W)'(1000));
        n = 0;
        while (sb.size() != 0 && n < 4*NDIG) begin
            step(1'b0, '0, '0, '0, 1'b1, a, r);
            n++;
        end
        check("t6_drain", (2*W)'(sb.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
